// File: rtl/lms_stim_gen_if.sv
// Sample bus between the LMS stimulus generator (master) and its consumer (slave).
interface lms_stim_gen_if #(
  parameter int SIG_WIDTH = 12,
  parameter int NOS_WIDTH = 12
);
  logic                        start;
  logic                        stop;
  logic signed [SIG_WIDTH-1:0] signal;
  logic signed [NOS_WIDTH-1:0] noise;
  logic                        sample_valid;
  logic                        busy;
  logic [15:0]                 sample_cnt;

  modport master (
    input  start, stop,
    output signal, noise, sample_valid, busy, sample_cnt
  );

  modport slave (
    output start, stop,
    input  signal, noise, sample_valid, busy, sample_cnt
  );
endinterface

// File: rtl/lms_stim_gen.sv
// Stimulus source for the LMS noise canceller: d(n) = tone(n) + P{x(n)} and reference noise x(n).
// Optional macro LMS_STIM_TONE_EN adds the triangle tone; without it signal carries only the path term.
module lms_stim_gen #(
  parameter int          SIG_WIDTH   = 12,
  parameter int          NOS_WIDTH   = 12,
  parameter int          CLK_DIV     = 16,
  parameter int          PHASE_WIDTH = 16,
  parameter int unsigned PHASE_INC   = 655,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned BURST_LEN   = 0
) (
  input  logic           clk,
  input  logic           rst,
  lms_stim_gen_if.master bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int P_W   = NOS_WIDTH + 2;
  localparam int SUM_W = ((SIG_WIDTH > NOS_WIDTH) ? SIG_WIDTH : NOS_WIDTH) + 3;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (SIG_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam bit          BURST_ON  = (BURST_LEN != 0);
  localparam logic [15:0] BURST_CNT = 16'(BURST_LEN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic signed [SIG_WIDTH-1:0] sat_sig(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[SIG_WIDTH-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[SIG_WIDTH-1:0];
    else
      return v[SIG_WIDTH-1:0];
  endfunction

  logic [0:0]                  state;
  logic [DIV_W-1:0]            div;
  logic [15:0]                 lfsr;
  logic signed [NOS_WIDTH-1:0] x0, x1, x2;
  logic                        lfsr_fb;
  logic                        emit;
  logic                        burst_end;

  logic signed [P_W-1:0]       x0_e, x1_e, x2_e, p, p_half;
  logic signed [SUM_W-1:0]     p_ext, tone_ext, sum;
  logic signed [SIG_WIDTH-1:0] tone;

  logic signed [SIG_WIDTH-1:0] signal_p0;
  logic signed [NOS_WIDTH-1:0] noise_p0;
  logic                        vld_p0;
  logic [15:0]                 cnt_p0;

  // Noise source and unknown path P (combinational from current state)
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign x0      = $signed(lfsr[15 -: NOS_WIDTH]);
  assign x0_e    = {{2{x0[NOS_WIDTH-1]}}, x0};
  assign x1_e    = {{2{x1[NOS_WIDTH-1]}}, x1};
  assign x2_e    = {{2{x2[NOS_WIDTH-1]}}, x2};
  assign p       = (x0_e >>> 1) - (x1_e >>> 2) + (x2_e >>> 3);
  assign p_half  = p >>> 1;
  assign p_ext   = {{(SUM_W - P_W){p_half[P_W-1]}}, p_half};

`ifdef LMS_STIM_TONE_EN
  localparam logic [SIG_WIDTH-1:0] TONE_OFS = SIG_WIDTH'(1 << (SIG_WIDTH - 2));
  logic [PHASE_WIDTH-1:0] phase;
  logic [SIG_WIDTH-1:0]   t;
  logic [SIG_WIDTH-2:0]   f;

  // Triangle: fold the upper half of the phase ramp back down, then centre on zero
  assign t    = phase[PHASE_WIDTH-1 -: SIG_WIDTH];
  assign f    = t[SIG_WIDTH-1] ? ~t[SIG_WIDTH-2:0] : t[SIG_WIDTH-2:0];
  assign tone = $signed({1'b0, f} - TONE_OFS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= '0;
    else if (state == ST_IDLE && bus.start && !bus.stop)
      phase <= '0;
    else if (emit)
      phase <= phase + PHASE_WIDTH'(PHASE_INC);
  end
`else
  logic unused_phase_cfg;
  assign unused_phase_cfg = ^{PHASE_INC[0], PHASE_WIDTH[0]};
  assign tone = '0;
`endif

  assign tone_ext  = {{(SUM_W - SIG_WIDTH){tone[SIG_WIDTH-1]}}, tone};
  assign sum       = tone_ext + p_ext;
  assign emit      = (state == ST_RUN) && !bus.stop && (div == DIV_LAST);
  assign burst_end = BURST_ON && ((cnt_p0 + 16'd1) == BURST_CNT);

  // Output stage p0: registered sample, valid strobe and run control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      div       <= '0;
      lfsr      <= LFSR_SEED;
      x1        <= '0;
      x2        <= '0;
      signal_p0 <= '0;
      noise_p0  <= '0;
      vld_p0    <= 1'b0;
      cnt_p0    <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            state  <= ST_RUN;
            div    <= '0;
            lfsr   <= LFSR_SEED;
            x1     <= '0;
            x2     <= '0;
            cnt_p0 <= '0;
          end
        end
        default: begin
          if (bus.stop) begin
            state <= ST_IDLE;
            div   <= '0;
          end else if (emit) begin
            div       <= '0;
            signal_p0 <= sat_sig(sum);
            noise_p0  <= x0;
            vld_p0    <= 1'b1;
            cnt_p0    <= cnt_p0 + 16'd1;
            lfsr      <= {lfsr[14:0], lfsr_fb};
            x2        <= x1;
            x1        <= x0;
            if (burst_end)
              state <= ST_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.signal       = signal_p0;
  assign bus.noise        = noise_p0;
  assign bus.sample_valid = vld_p0;
  assign bus.busy         = (state == ST_RUN);
  assign bus.sample_cnt   = cnt_p0;
endmodule

// File: tb/tb_lms_stim_gen.sv
// Scoreboard bench for lms_stim_gen: a continuous default instance and an 8-bit burst instance.
module tb_lms_stim_gen;
  typedef struct {
    int sig;
    int nos;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  lms_stim_gen_if #(.SIG_WIDTH(12), .NOS_WIDTH(12)) if0 ();
  lms_stim_gen_if #(.SIG_WIDTH(8),  .NOS_WIDTH(12)) if1 ();

  lms_stim_gen d0 (.clk(clk), .rst(rst), .bus(if0));
  lms_stim_gen #(.SIG_WIDTH(8), .CLK_DIV(4), .BURST_LEN(5)) d1 (.clk(clk), .rst(rst), .bus(if1));

  function automatic int model_signal(input int x0, input int x1, input int x2,
                                      input int phase, input int sig_w);
    int p, ph, t, lo, f, tone, hi, s;
    p  = (x0 >>> 1) - (x1 >>> 2) + (x2 >>> 3);
    ph = p >>> 1;
    t  = (phase >> (16 - sig_w)) & ((1 << sig_w) - 1);
    lo = t & ((1 << (sig_w - 1)) - 1);
    f  = ((t >> (sig_w - 1)) & 1) ? (~lo & ((1 << (sig_w - 1)) - 1)) : lo;
    tone = f - (1 << (sig_w - 2));
`ifndef LMS_STIM_TONE_EN
    tone = 0;
`endif
    hi = (1 << (sig_w - 1)) - 1;
    s  = tone + ph;
    if (s > hi) s = hi;
    if (s < -hi - 1) s = -hi - 1;
    return s;
  endfunction

  task automatic push_run(input int n, input int sig_w, input bit sel);
    logic [15:0] lfsr;
    int x0, x1, x2, phase;
    exp_t e;
    lfsr = 16'hACE1; x1 = 0; x2 = 0; phase = 0;
    for (int i = 0; i < n; i++) begin
      x0 = int'(lfsr[15:4]);
      if (x0 >= 2048) x0 -= 4096;
      e.sig = model_signal(x0, x1, x2, phase, sig_w);
      e.nos = x0;
      e.cnt = (i + 1) & 16'hFFFF;
      if (sel) q1.push_back(e); else q0.push_back(e);
      phase = (phase + 655) & 16'hFFFF;
      lfsr  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      x2 = x1;
      x1 = x0;
    end
  endtask

  // Advances negedge by negedge until the selected DUT strobes valid or the budget runs out.
  task automatic wait_valid(input bit sel, input int budget, output bit got, output int cycles);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if ((sel ? if1.sample_valid : if0.sample_valid) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic pulse_start0();
    @(negedge clk); if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
  endtask

  task automatic test_reset();
    bit got; int cyc, nv;
    repeat (3) @(negedge clk);
    n_cmp++; if (int'(if0.signal) !== 0 || int'(if0.noise) !== 0 || if0.busy !== 1'b0 ||
                 if0.sample_valid !== 1'b0 || int'(if0.sample_cnt) !== 0) begin
      n_bad++; $display("FAIL reset_init: got sig=%0d nos=%0d busy=%b vld=%b cnt=%0d expected all 0",
                        int'(if0.signal), int'(if0.noise), if0.busy, if0.sample_valid, int'(if0.sample_cnt));
    end
    rst = 1'b0;
    pulse_start0();
    wait_valid(1'b0, 40, got, cyc);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL reset_prerun_valid: got none expected one"); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (int'(if0.signal) !== 0 || int'(if0.noise) !== 0 || if0.busy !== 1'b0 ||
                 if0.sample_valid !== 1'b0 || int'(if0.sample_cnt) !== 0) begin
      n_bad++; $display("FAIL reset_midrun: got sig=%0d nos=%0d busy=%b vld=%b cnt=%0d expected all 0",
                        int'(if0.signal), int'(if0.noise), if0.busy, if0.sample_valid, int'(if0.sample_cnt));
    end
    rst = 1'b0;
    nv = 0;
    repeat (50) begin @(negedge clk); if (if0.sample_valid !== 1'b0) nv++; end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL reset_quiet: got %0d valids expected 0", nv); end
  endtask

  task automatic test_stream();
    bit got; int cyc, first_sig, exp_gap, last_sig;
    exp_t e;
`ifdef LMS_STIM_TONE_EN
    first_sig = -1357;
`else
    first_sig = -333;
`endif
    q0.delete();
    push_run(1000, 12, 1'b0);
    pulse_start0();
    n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b expected 1", if0.busy); end
    last_sig = 0;
    for (int i = 0; i < 1000; i++) begin
      exp_gap = 16;
      if (i == 501) exp_gap = 14;
      wait_valid(1'b0, 40, got, cyc);
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL stream_timeout[%0d]: got none expected valid", i); break; end
      if (cyc !== exp_gap) begin n_bad++; $display("FAIL stream_gap[%0d]: got %0d expected %0d", i, cyc, exp_gap); end
      e = q0.pop_front();
      last_sig = e.sig;
      n_cmp++; if (int'(if0.signal) !== e.sig) begin
        n_bad++; $display("FAIL stream_signal[%0d]: got %0d expected %0d", i, int'(if0.signal), e.sig); end
      n_cmp++; if (int'(if0.noise) !== e.nos) begin
        n_bad++; $display("FAIL stream_noise[%0d]: got %0d expected %0d", i, int'(if0.noise), e.nos); end
      n_cmp++; if (int'(if0.sample_cnt) !== e.cnt) begin
        n_bad++; $display("FAIL stream_cnt[%0d]: got %0d expected %0d", i, int'(if0.sample_cnt), e.cnt); end
      if (i == 0) begin
        n_cmp++; if (int'(if0.noise) !== -1330 || int'(if0.signal) !== first_sig) begin
          n_bad++; $display("FAIL first_sample: got sig=%0d nos=%0d expected sig=%0d nos=-1330",
                            int'(if0.signal), int'(if0.noise), first_sig); end
      end
      if (i == 500) pulse_start0();
    end
    @(negedge clk); if0.stop = 1'b1;
    @(negedge clk); if0.stop = 1'b0;
    n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b expected 0", if0.busy); end
    wait_valid(1'b0, 40, got, cyc);
    n_cmp++; if (got) begin n_bad++; $display("FAIL stop_quiet: got valid after %0d cycles expected none", cyc); end
    n_cmp++; if (int'(if0.signal) !== last_sig) begin
      n_bad++; $display("FAIL idle_hold: got %0d expected %0d", int'(if0.signal), last_sig); end
  endtask

  task automatic test_stop_on_emit();
    bit got; int cyc;
    exp_t e;
    q0.delete();
    push_run(1, 12, 1'b0);
    pulse_start0();
    wait_valid(1'b0, 40, got, cyc);
    n_cmp++; if (!got || cyc !== 16) begin
      n_bad++; $display("FAIL soe_first: got valid=%b after %0d expected valid after 16", got, cyc); end
    e = q0.pop_front();
    repeat (15) @(negedge clk);
    if0.stop = 1'b1;
    @(negedge clk); if0.stop = 1'b0;
    n_cmp++; if (if0.sample_valid !== 1'b0 || if0.busy !== 1'b0) begin
      n_bad++; $display("FAIL soe_suppress: got vld=%b busy=%b expected 0 0", if0.sample_valid, if0.busy); end
    n_cmp++; if (int'(if0.sample_cnt) !== 1 || int'(if0.signal) !== e.sig) begin
      n_bad++; $display("FAIL soe_hold: got cnt=%0d sig=%0d expected cnt=1 sig=%0d",
                        int'(if0.sample_cnt), int'(if0.signal), e.sig); end
    wait_valid(1'b0, 40, got, cyc);
    n_cmp++; if (got) begin n_bad++; $display("FAIL soe_quiet: got valid expected none"); end
  endtask

  task automatic test_start_stop_idle();
    bit got; int cyc;
    @(negedge clk); if0.start = 1'b1; if0.stop = 1'b1;
    @(negedge clk); if0.start = 1'b0; if0.stop = 1'b0;
    n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL ss_idle_busy: got %b expected 0", if0.busy); end
    wait_valid(1'b0, 40, got, cyc);
    n_cmp++; if (got || if0.busy !== 1'b0) begin
      n_bad++; $display("FAIL ss_idle_quiet: got valid=%b busy=%b expected 0 0", got, if0.busy); end
  endtask

  task automatic test_burst();
    bit got; int cyc;
    exp_t e;
    q1.delete();
    for (int run = 0; run < 2; run++) begin
      push_run(5, 8, 1'b1);
      @(negedge clk); if1.start = 1'b1;
      @(negedge clk); if1.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        wait_valid(1'b1, 20, got, cyc);
        n_cmp++;
        if (!got || cyc !== 4) begin
          n_bad++; $display("FAIL burst_timing[%0d.%0d]: got valid=%b after %0d expected after 4", run, i, got, cyc);
          if (!got) break;
        end
        e = q1.pop_front();
        n_cmp++; if (int'(if1.signal) !== e.sig || int'(if1.noise) !== e.nos || int'(if1.sample_cnt) !== e.cnt) begin
          n_bad++; $display("FAIL burst_sample[%0d.%0d]: got sig=%0d nos=%0d cnt=%0d expected sig=%0d nos=%0d cnt=%0d",
                            run, i, int'(if1.signal), int'(if1.noise), int'(if1.sample_cnt), e.sig, e.nos, e.cnt); end
        if (i == 0) begin
          n_cmp++; if (int'(if1.signal) !== -128) begin
            n_bad++; $display("FAIL burst_clamp: got %0d expected -128", int'(if1.signal)); end
        end
        if (i == 4) begin
          n_cmp++; if (if1.busy !== 1'b0) begin n_bad++; $display("FAIL burst_busy_fall: got %b expected 0", if1.busy); end
        end
      end
      wait_valid(1'b1, 30, got, cyc);
      n_cmp++; if (got) begin n_bad++; $display("FAIL burst_extra[%0d]: got extra valid expected none", run); end
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.stop = 1'b0;
    if1.start = 1'b0; if1.stop = 1'b0;
    test_reset();
    test_stream();
    test_stop_on_emit();
    test_start_stop_idle();
    test_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
